// File: rtl/zeroheti_pkg.sv
// zeroHETI shared definitions: machine-timer window offsets, register selector and byte-merge helper.
package zeroheti_pkg;

  localparam logic [31:0] MtimerAddr     = 32'h0000_2100;
  localparam logic [31:0] MtimeLoOffs    = 32'h0000_0000;
  localparam logic [31:0] MtimeHiOffs    = 32'h0000_0004;
  localparam logic [31:0] MtimecmpLoOffs = 32'h0000_0008;
  localparam logic [31:0] MtimecmpHiOffs = 32'h0000_000C;
  localparam logic [31:0] MtimerCtrlOffs = 32'h0000_0010;
  localparam logic [31:0] MtimerWinSize  = 32'h0000_0014;

  typedef enum logic [2:0] {
    MTIMER_MTIME_LO = 3'd0,
    MTIMER_MTIME_HI = 3'd1,
    MTIMER_CMP_LO   = 3'd2,
    MTIMER_CMP_HI   = 3'd3,
    MTIMER_CTRL     = 3'd4
  } mtimer_reg_e;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = be[i] ? wdata[i*8 +: 8] : old_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/zeroheti_prescaler.sv
// Tick generator for the machine timer: one tick every (prescale+1) enabled cycles.
// Compiled only when MTIMER_PRESCALER_EN is defined.
`ifdef MTIMER_PRESCALER_EN
module zeroheti_prescaler (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic [7:0] prescale_i,
  input  logic       clear_i,
  output logic       tick_o
);

  logic [7:0] cnt_r;
  logic       wrap_s;

  assign wrap_s = (cnt_r == prescale_i);
  assign tick_o = enable_i && wrap_s;

  // Prescale counter, restarted by any control write
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r <= 8'h00;
    end else if (clear_i) begin
      cnt_r <= 8'h00;
    end else if (enable_i) begin
      cnt_r <= wrap_s ? 8'h00 : cnt_r + 8'h01;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule
`endif

// File: rtl/zeroheti_mtimer.sv
// RISC-V machine timer OBI responder (mtime, mtimecmp, ctrl) with level timer interrupt.
// Optional prescaler enabled by defining MTIMER_PRESCALER_EN.
module zeroheti_mtimer
  import zeroheti_pkg::*;
#(
  parameter logic [31:0] BaseAddr  = MtimerAddr,
  parameter logic [63:0] CmpRstVal = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        timer_irq_o
);

  logic [63:0] mtime_r, mtime_nxt_s, mtime_wr_val_s;
  logic [63:0] mtimecmp_r, mtimecmp_nxt_s;
  logic        enable_r, enable_nxt_s;
  logic [7:0]  prescale_rd_s;
  logic [31:0] offset_s, reg_val_s, rdata_r;
  logic        err_s, rd_s, wr_s, mtime_wr_s, ctrl_wr_s, tick_s;
  logic        rvalid_r, err_r, irq_r;
  mtimer_reg_e reg_sel_s;

  assign gnt_o       = req_i;
  assign rvalid_o    = rvalid_r;
  assign rdata_o     = rdata_r;
  assign err_o       = err_r;
  assign timer_irq_o = irq_r;

`ifdef MTIMER_PRESCALER_EN
  logic [7:0] prescale_r, prescale_nxt_s;
  assign prescale_rd_s = prescale_r;

  zeroheti_prescaler u_prescaler (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .enable_i   (enable_r),
    .prescale_i (prescale_r),
    .clear_i    (ctrl_wr_s),
    .tick_o     (tick_s)
  );
`else
  assign prescale_rd_s = 8'h00;
  assign tick_s        = enable_r;
`endif

  // Address decode; addresses below the base wrap to a large offset and fault
  always_comb begin
    offset_s  = addr_i - BaseAddr;
    err_s     = (offset_s >= MtimerWinSize) || (addr_i[1:0] != 2'b00);
    reg_sel_s = mtimer_reg_e'(offset_s[4:2]);
    rd_s      = req_i && !we_i && !err_s;
    wr_s      = req_i && we_i && !err_s;
  end

  // Read mux over the current (pre-update) register values
  always_comb begin
    case (reg_sel_s)
      MTIMER_MTIME_LO: reg_val_s = mtime_r[31:0];
      MTIMER_MTIME_HI: reg_val_s = mtime_r[63:32];
      MTIMER_CMP_LO:   reg_val_s = mtimecmp_r[31:0];
      MTIMER_CMP_HI:   reg_val_s = mtimecmp_r[63:32];
      MTIMER_CTRL:     reg_val_s = {16'h0000, prescale_rd_s, 7'h00, enable_r};
      default:         reg_val_s = 32'h0000_0000;
    endcase
  end

  // Register writes; a non-empty mtime write takes priority over counting
  always_comb begin
    mtime_wr_val_s = mtime_r;
    mtimecmp_nxt_s = mtimecmp_r;
    enable_nxt_s   = enable_r;
    mtime_wr_s     = 1'b0;
    ctrl_wr_s      = 1'b0;
`ifdef MTIMER_PRESCALER_EN
    prescale_nxt_s = prescale_r;
`endif
    if (wr_s) begin
      case (reg_sel_s)
        MTIMER_MTIME_LO: begin
          mtime_wr_val_s[31:0] = be_merge(mtime_r[31:0], wdata_i, be_i);
          mtime_wr_s           = (be_i != 4'b0000);
        end
        MTIMER_MTIME_HI: begin
          mtime_wr_val_s[63:32] = be_merge(mtime_r[63:32], wdata_i, be_i);
          mtime_wr_s            = (be_i != 4'b0000);
        end
        MTIMER_CMP_LO: mtimecmp_nxt_s[31:0]  = be_merge(mtimecmp_r[31:0], wdata_i, be_i);
        MTIMER_CMP_HI: mtimecmp_nxt_s[63:32] = be_merge(mtimecmp_r[63:32], wdata_i, be_i);
        MTIMER_CTRL: begin
          ctrl_wr_s    = 1'b1;
          enable_nxt_s = be_i[0] ? wdata_i[0] : enable_r;
`ifdef MTIMER_PRESCALER_EN
          prescale_nxt_s = be_i[1] ? wdata_i[15:8] : prescale_r;
`endif
        end
        default: ctrl_wr_s = 1'b0;
      endcase
    end else begin
      mtime_wr_s = 1'b0;
    end

    if (mtime_wr_s) begin
      mtime_nxt_s = mtime_wr_val_s;
    end else if (tick_s) begin
      mtime_nxt_s = mtime_r + 64'd1;
    end else begin
      mtime_nxt_s = mtime_r;
    end
  end

  // Timer state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_r    <= 64'd0;
      mtimecmp_r <= CmpRstVal;
      enable_r   <= 1'b0;
`ifdef MTIMER_PRESCALER_EN
      prescale_r <= 8'h00;
`endif
    end else begin
      mtime_r    <= mtime_nxt_s;
      mtimecmp_r <= mtimecmp_nxt_s;
      enable_r   <= enable_nxt_s;
`ifdef MTIMER_PRESCALER_EN
      prescale_r <= prescale_nxt_s;
`endif
    end
  end

  // OBI response, one cycle after grant, plus registered compare
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
      rdata_r  <= 32'h0000_0000;
      irq_r    <= 1'b0;
    end else begin
      rvalid_r <= req_i;
      err_r    <= req_i && err_s;
      rdata_r  <= rd_s ? reg_val_s : 32'h0000_0000;
      irq_r    <= (mtime_r >= mtimecmp_r);
    end
  end

endmodule
